cnn_frame_scheduler: RTL and testbench

Frame-level sequencer for the conv2 stage (`layer2_block`). It admits exactly one 12×12×6 pooled frame from the layer-1 stream per `start` command and gates the stage's input valid. It counts the 16 pooled conv2 results, reports frame completion, and detects stray input and stalled computation.

---
 rtl/cnn_sched_pkg.sv | 16 +
 rtl/sched_watchdog.sv | 29 ++
 rtl/cnn_frame_scheduler.sv | 168 ++++++++++++++++
 tb/tb_cnn_frame_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared types and default geometry for the conv2 frame scheduler.
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_COMPUTE,
    ST_DONE,
    ST_ERR
  } sched_state_t;

  // 12x12 pooled layer-1 frame in, 4x4 pooled conv2 results out
  localparam int unsigned L2_IN_PIXELS  = 144;
  localparam int unsigned L2_OUT_PIXELS = 16;

endpackage

// File: rtl/sched_watchdog.sv
// Idle-gap watchdog: counts cycles between kicks while run is high and
// flags when the gap reaches TIMEOUT_CYCLES-1.
module sched_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Gap counter: cleared by a kick, otherwise advances while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (kick) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cnn_frame_scheduler.sv
// Frame-level sequencer for the conv2 stage: admits one pooled frame per
// start, counts conv2 results, reports completion, drops and stalls.
// Optional build macro SCHED_PERF_EN adds a per-frame cycle counter.
module cnn_frame_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int unsigned IN_PIXELS      = L2_IN_PIXELS,
  parameter int unsigned OUT_PIXELS     = L2_OUT_PIXELS,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             src_valid,
  output logic             l2_valid_in,
  input  logic             l2_out_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             err_drop,
  output logic             timeout,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [31:0]      frame_cycles
);

  localparam int unsigned IN_W  = (IN_PIXELS  > 1) ? $clog2(IN_PIXELS)  : 1;
  localparam int unsigned OUT_W = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

  sched_state_t     state;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic             in_feed;
  logic             in_comp;
  logic             busy_st;
  logic             drop;
  logic             kick;
  logic             expired;

  assign in_feed = (state == ST_FEED);
  assign in_comp = (state == ST_COMPUTE);
  assign busy_st = in_feed || in_comp;
  assign drop    = src_valid && !in_feed;
  assign kick    = ((state == ST_IDLE) && start) ||
                   (in_feed && src_valid) ||
                   (in_comp && l2_out_valid);

  // Data bypasses this block; only the valid is gated, with zero latency
  assign l2_valid_in = in_feed && src_valid;

  sched_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (kick),
    .run     (busy_st),
    .expired (expired)
  );

  // Frame FSM with registered busy/frame_done/timeout; a counted event
  // takes priority over a watchdog expiry on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FEED;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_FEED: begin
          if (src_valid) begin
            if (in_cnt == IN_W'(IN_PIXELS - 1)) begin
              state <= ST_COMPUTE;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end else if (expired) begin
            state   <= ST_ERR;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (l2_out_valid) begin
            if (out_cnt == OUT_W'(OUT_PIXELS - 1)) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end else if (expired) begin
            state   <= ST_ERR;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ERR: begin
          if (clear) begin
            state   <= ST_IDLE;
            timeout <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  // Dropped-beat accounting; clear wins but still flags a beat it drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err_drop <= 1'b0;
    end else if (clear) begin
      drop_cnt <= '0;
      err_drop <= drop;
    end else if (drop) begin
      err_drop <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] perf_cnt;

  // Frame latency: restart on FEED entry, count busy cycles, latch in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt     <= '0;
      frame_cycles <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        perf_cnt <= '0;
      end else if (busy_st) begin
        perf_cnt <= perf_cnt + 1'b1;
      end
      if (state == ST_DONE) begin
        frame_cycles <= perf_cnt;
      end
    end
  end
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Self-checking bench for cnn_frame_scheduler: directed frames, a segment
// table with expected outputs, and random traffic against a frame model.
module tb_cnn_frame_scheduler;

  localparam int unsigned IN_PIX   = 144;
  localparam int unsigned OUT_PIX  = 16;
  localparam int unsigned TO_CYC   = 20;
  localparam int unsigned DROP_MAX = 65535;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        src_valid;
  logic        l2_valid_in;
  logic        l2_out_valid;
  logic        busy;
  logic        frame_done;
  logic        err_drop;
  logic        timeout;
  logic [15:0] drop_cnt;
  logic [31:0] frame_cycles;

  cnn_frame_scheduler #(
    .IN_PIXELS      (IN_PIX),
    .OUT_PIXELS     (OUT_PIX),
    .TIMEOUT_CYCLES (TO_CYC),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .src_valid    (src_valid),
    .l2_valid_in  (l2_valid_in),
    .l2_out_valid (l2_out_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_drop     (err_drop),
    .timeout      (timeout),
    .drop_cnt     (drop_cnt),
    .frame_cycles (frame_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  int done_seen = 0;

  // Frame model: what is still owed by the frame, and the current idle gap
  bit          m_feeding, m_computing, m_done, m_err, m_err_drop;
  int          m_beats_left, m_results_left, m_gap;
  int unsigned m_drops, m_run_cycles, m_last_frame;

  function automatic void model_reset();
    m_feeding = 0; m_computing = 0; m_done = 0; m_err = 0; m_err_drop = 0;
    m_beats_left = 0; m_results_left = 0; m_gap = 0;
    m_drops = 0; m_run_cycles = 0; m_last_frame = 0;
  endfunction

  function automatic void model_edge(input bit s, input bit c, input bit v, input bit o);
    bit dropped;
    dropped = v && !m_feeding;
    if (c) begin
      m_drops = 0;
      m_err_drop = dropped;
    end else if (dropped) begin
      m_err_drop = 1;
      if (m_drops < DROP_MAX) m_drops++;
    end
    if (m_feeding || m_computing) m_run_cycles++;
    if (m_done) begin
      m_last_frame = m_run_cycles;
      m_done = 0;
    end else if (m_err) begin
      if (c) m_err = 0;
    end else if (m_feeding) begin
      if (v) begin
        m_gap = 0;
        m_beats_left--;
        if (m_beats_left == 0) begin
          m_feeding = 0;
          m_computing = 1;
          m_results_left = OUT_PIX;
        end
      end else if (m_gap == TO_CYC - 1) begin
        m_feeding = 0;
        m_err = 1;
      end else begin
        m_gap++;
      end
    end else if (m_computing) begin
      if (o) begin
        m_gap = 0;
        m_results_left--;
        if (m_results_left == 0) begin
          m_computing = 0;
          m_done = 1;
        end
      end else if (m_gap == TO_CYC - 1) begin
        m_computing = 0;
        m_err = 1;
      end else begin
        m_gap++;
      end
    end else if (s) begin
      m_feeding = 1;
      m_beats_left = IN_PIX;
      m_gap = 0;
      m_run_cycles = 0;
    end
  endfunction

  function automatic logic [31:0] exp_frame_cycles();
`ifdef SCHED_PERF_EN
    return m_last_frame;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every output against the model, mid-cycle
  task automatic check_outputs(input bit v);
    logic [52:0] got_v, exp_v;
    got_v = {l2_valid_in, busy, frame_done, err_drop, timeout, drop_cnt, frame_cycles};
    exp_v = {m_feeding && v, m_feeding || m_computing, m_done, m_err_drop, m_err,
             16'(m_drops), exp_frame_cycles()};
    if (l2_valid_in === 1'b1) pulses++;
    if (frame_done === 1'b1) done_seen++;
    check("cyc", 64'(got_v), 64'(exp_v));
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge
  task automatic step(input bit s, input bit c, input bit v, input bit o);
    start = s; clear = c; src_valid = v; l2_out_valid = o;
    #4;
    check_outputs(v);
    @(posedge clk);
    model_edge(s, c, v, o);
    #1;
  endtask

  typedef struct {
    bit s, c, v, o;
    int reps;
    bit busy, done, errd, to;
    int drop;
  } seg_t;

  seg_t tbl[$];

  initial begin
    tbl.push_back('{0,0,1,0,   3, 0,0,1,0, 3});  // beats in IDLE are dropped
    tbl.push_back('{1,0,0,0,   1, 1,0,1,0, 3});
    tbl.push_back('{0,0,1,0, 144, 1,0,1,0, 3});
    tbl.push_back('{0,0,1,0,   2, 1,0,1,0, 5});  // beats in COMPUTE dropped
    tbl.push_back('{0,0,0,1,  15, 1,0,1,0, 5});
    tbl.push_back('{0,0,0,1,   1, 0,1,1,0, 5});
    tbl.push_back('{0,0,0,0,   1, 0,0,1,0, 5});
    tbl.push_back('{0,1,0,0,   1, 0,0,0,0, 0});
    tbl.push_back('{1,0,0,0,   1, 1,0,0,0, 0});  // stall after 100 beats
    tbl.push_back('{0,0,1,0, 100, 1,0,0,0, 0});
    tbl.push_back('{0,0,0,0,  19, 1,0,0,0, 0});
    tbl.push_back('{0,0,0,0,   1, 0,0,0,1, 0});
    tbl.push_back('{1,0,0,0,   1, 0,0,0,1, 0});  // start ignored in ERR
    tbl.push_back('{0,0,1,0,   1, 0,0,1,1, 1});
    tbl.push_back('{0,1,0,0,   1, 0,0,0,0, 0});
    tbl.push_back('{1,0,1,0,   1, 1,0,1,0, 1});  // coincident beat dropped
    tbl.push_back('{0,0,1,0,  70, 1,0,1,0, 1});
    tbl.push_back('{1,0,1,0,   1, 1,0,1,0, 1});  // mid-FEED start ignored
    tbl.push_back('{0,0,1,0,  73, 1,0,1,0, 1});
    tbl.push_back('{0,0,0,1,  16, 0,1,1,0, 1});
    tbl.push_back('{1,0,0,0,   1, 0,0,1,0, 1});  // start in DONE ignored
    tbl.push_back('{0,1,0,0,   1, 0,0,0,0, 0});

    rst_n = 1'b0; start = 0; clear = 0; src_valid = 0; l2_out_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 64'({l2_valid_in, busy, frame_done, err_drop, timeout, drop_cnt, frame_cycles}), 64'd0);
    rst_n = 1'b1;

    // Single frame, results spaced 10 cycles apart
    pulses = 0; done_seen = 0;
    step(1, 0, 0, 0);
    repeat (IN_PIX) step(0, 0, 1, 0);
    for (int i = 0; i < int'(OUT_PIX); i++) begin
      repeat (9) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
    end
    check("t1_done_pulse", 64'(frame_done), 64'd1);
    check("t1_busy_fall", 64'(busy), 64'd0);
    repeat (3) step(0, 0, 0, 0);
    check("t1_fwd_count", 64'(pulses), 64'(IN_PIX));
    check("t1_done_cycles", 64'(done_seen), 64'd1);
    check("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // Reset in the middle of a frame
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (70) step(0, 0, 1, 0);
    rst_n = 1'b0;
    model_reset();
    #4;
    check("t5_rst_outs", 64'({l2_valid_in, busy, frame_done, err_drop, timeout, drop_cnt, frame_cycles}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back frame for latency measurement
    step(1, 0, 0, 0);
    repeat (IN_PIX) step(0, 0, 1, 0);
    repeat (OUT_PIX) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
`ifdef SCHED_PERF_EN
    check("t6_frame_cycles", 64'(frame_cycles), 64'd160);
`else
    check("t6_frame_cycles", 64'(frame_cycles), 64'd0);
`endif
    step(0, 0, 0, 0);

    // Segment table
    for (int k = 0; k < tbl.size(); k++) begin
      repeat (tbl[k].reps) step(tbl[k].s, tbl[k].c, tbl[k].v, tbl[k].o);
      check($sformatf("seg%0d", k),
            64'({busy, frame_done, err_drop, timeout, drop_cnt}),
            64'({tbl[k].busy, tbl[k].done, tbl[k].errd, tbl[k].to, 16'(tbl[k].drop)}));
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
